// File: rtl/tlu_handshake_core.sv
// tlu_handshake_core
// TLU trigger receiver: masked and synchronised trigger inputs, the three
// EUDET handshake modes, and one 32-bit word per accepted trigger on a
// valid/ready stream. Trigger, dropped-trigger and timeout bookkeeping
// are kept alongside the handshake state machine.
module tlu_handshake_core #(
   parameter int N_INPUTS   = 4,
   parameter int TRIG_WIDTH = 15,
   parameter int DIVISOR    = 12
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST_N,
   input  logic [N_INPUTS-1:0] TRIG_IN,
   input  logic [N_INPUTS-1:0] CHAN_MASK,
   input  logic [1:0]          MODE,
   input  logic                MSB_FIRST,
   input  logic [3:0]          DATA_DELAY,
   input  logic [7:0]          LOW_TIMEOUT,
   input  logic                DISABLE_VETO,
   input  logic                FIFO_NEAR_FULL,
   input  logic                CLR,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic [31:0]         OUT_DATA,
   output logic                TLU_BUSY,
   output logic                TLU_CLOCK,
   output logic [31:0]         TRIG_CNT,
   output logic [15:0]         DROP_CNT,
   output logic                TIMEOUT_ERR
);

   localparam logic [7:0] HALF_M1  = 8'(DIVISOR / 2 - 1);
   localparam logic [4:0] LAST_BIT = 5'(TRIG_WIDTH - 1);
   localparam logic [4:0] WIDTH5   = 5'(TRIG_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_WAIT_LOW,
      ST_SHIFT
   } state_t;

   state_t              r_state;
   logic [1:0]          r_mode;
   logic [N_INPUTS-1:0] r_sync1, r_sync2, r_sync3;
   logic                r_trigPrev;
   logic                r_outValid;
   logic [31:0]         r_outData;
   logic                r_busy;
   logic                r_tluClk;
   logic [31:0]         r_trigCnt;
   logic [15:0]         r_dropCnt;
   logic                r_timeoutErr;
   logic [7:0]          r_lowCnt;
   logic [7:0]          r_divCnt;
   logic [4:0]          r_bitCnt;
   logic [4:0]          r_fallCnt;
   logic [3:0]          r_delayCnt;
   logic                r_pending;
   logic [31:0]         r_shift;

   logic                w_trig;
   logic                w_event;
   logic [1:0]          w_effMode;
   logic                w_accept;
   logic                w_drop;
   logic                w_veto;
   logic [31:0]         w_cntInc;
   logic                w_timeout;
   logic                w_falling;
   logic                w_sample;
   logic [4:0]          w_bitIdx;
   logic [31:0]         w_shiftNext;

   assign w_trig    = |(r_sync3 & CHAN_MASK);
   assign w_event   = w_trig & ~r_trigPrev;
   assign w_effMode = (r_state == ST_IDLE) ? MODE : r_mode;
   assign w_accept  = (r_state == ST_IDLE) && (MODE != 2'b00) && w_event && !FIFO_NEAR_FULL;
   assign w_drop    = w_event && (w_effMode == 2'b01) && ((r_state != ST_IDLE) || FIFO_NEAR_FULL);
   assign w_veto    = MODE[1] & FIFO_NEAR_FULL & ~DISABLE_VETO;
   assign w_cntInc  = r_trigCnt + 32'd1;
   assign w_timeout = (r_state == ST_WAIT_LOW) && w_trig && (LOW_TIMEOUT != 8'd0) &&
                      ((r_lowCnt + 8'd1) == LOW_TIMEOUT);
   assign w_falling = (r_state == ST_SHIFT) && r_tluClk && (r_divCnt == HALF_M1);
   assign w_sample  = (r_state == ST_SHIFT) &&
                      ((w_falling && (DATA_DELAY == 4'd0)) || (r_pending && (r_delayCnt == 4'd1)));
   assign w_bitIdx  = MSB_FIRST ? (LAST_BIT - r_bitCnt) : r_bitCnt;

   // Place the sampled trigger-line bit at its final position in the number
   always_comb begin
      w_shiftNext = r_shift;
      if (w_sample) begin
         w_shiftNext[w_bitIdx] = w_trig;
      end
   end

   // Three-stage synchroniser on the raw trigger pins plus edge-detect history
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_sync3    <= '0;
         r_trigPrev <= 1'b0;
      end else begin
         r_sync1    <= TRIG_IN;
         r_sync2    <= r_sync1;
         r_sync3    <= r_sync2;
         r_trigPrev <= w_trig;
      end
   end

   // Trigger/drop counters and sticky timeout flag; a clear beats any update
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         r_trigCnt    <= '0;
         r_dropCnt    <= '0;
         r_timeoutErr <= 1'b0;
      end else if (CLR) begin
         r_trigCnt    <= '0;
         r_dropCnt    <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         if (w_accept) begin
            r_trigCnt <= w_cntInc;
         end
         if (w_drop && (r_dropCnt != 16'hFFFF)) begin
            r_dropCnt <= r_dropCnt + 16'd1;
         end
         if (w_timeout) begin
            r_timeoutErr <= 1'b1;
         end
      end
   end

   // Handshake state machine with registered stream and TLU outputs
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RST_N) begin
         r_state    <= ST_IDLE;
         r_mode     <= 2'b00;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_busy     <= 1'b0;
         r_tluClk   <= 1'b0;
         r_lowCnt   <= '0;
         r_divCnt   <= '0;
         r_bitCnt   <= '0;
         r_fallCnt  <= '0;
         r_delayCnt <= '0;
         r_pending  <= 1'b0;
         r_shift    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_busy <= w_veto;
               if (w_accept) begin
                  r_mode   <= MODE;
                  r_lowCnt <= '0;
                  if (MODE == 2'b01) begin
                     r_state    <= ST_EMIT;
                     r_outValid <= 1'b1;
                     r_outData  <= {1'b1, w_cntInc[30:0]};
                  end else begin
                     r_state <= ST_WAIT_LOW;
                     r_busy  <= 1'b1;
                     if (MODE == 2'b10) begin
                        r_outData <= {1'b1, w_cntInc[30:0]};
                     end
                  end
               end
            end
            ST_WAIT_LOW: begin
               if (!w_trig) begin
                  if (r_mode == 2'b11) begin
                     r_state   <= ST_SHIFT;
                     r_tluClk  <= 1'b1;
                     r_divCnt  <= '0;
                     r_bitCnt  <= '0;
                     r_fallCnt <= '0;
                     r_pending <= 1'b0;
                     r_shift   <= '0;
                  end else begin
                     r_state    <= ST_EMIT;
                     r_outValid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_state <= ST_IDLE;
                  r_busy  <= w_veto;
               end else begin
                  r_lowCnt <= r_lowCnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (r_divCnt == HALF_M1) begin
                  r_divCnt <= '0;
                  if (r_tluClk) begin
                     r_tluClk  <= 1'b0;
                     r_fallCnt <= r_fallCnt + 5'd1;
                  end else if (r_fallCnt != WIDTH5) begin
                     r_tluClk <= 1'b1;
                  end
               end else begin
                  r_divCnt <= r_divCnt + 8'd1;
               end
               if (w_sample) begin
                  r_shift   <= w_shiftNext;
                  r_bitCnt  <= r_bitCnt + 5'd1;
                  r_pending <= 1'b0;
               end else if (r_pending) begin
                  r_delayCnt <= r_delayCnt - 4'd1;
               end
               if (w_falling && (DATA_DELAY != 4'd0)) begin
                  r_pending  <= 1'b1;
                  r_delayCnt <= DATA_DELAY;
               end
               if (w_sample && (r_bitCnt == LAST_BIT)) begin
                  r_state    <= ST_EMIT;
                  r_outValid <= 1'b1;
                  r_outData  <= {1'b1, w_shiftNext[30:0]};
                  r_tluClk   <= 1'b0;
               end
            end
            ST_EMIT: begin
               if (OUT_READY) begin
                  r_outValid <= 1'b0;
                  r_state    <= ST_IDLE;
                  r_busy     <= w_veto;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign OUT_VALID   = r_outValid;
   assign OUT_DATA    = r_outData;
   assign TLU_BUSY    = r_busy;
   assign TLU_CLOCK   = r_tluClk;
   assign TRIG_CNT    = r_trigCnt;
   assign DROP_CNT    = r_dropCnt;
   assign TIMEOUT_ERR = r_timeoutErr;

endmodule

// File: tb/tb_tlu_handshake_core.sv
// tb_tlu_handshake_core
// Directed bench for the TLU handshake core: a table of single-trigger
// vectors for modes 00/01/10 followed by hand-written sequences for the
// data handshake, backpressure, low timeout, drops, clear and reset.
module tb_tlu_handshake_core;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST_N;
   logic [3:0]  TRIG_IN;
   logic [3:0]  CHAN_MASK;
   logic [1:0]  MODE;
   logic        MSB_FIRST;
   logic [3:0]  DATA_DELAY;
   logic [7:0]  LOW_TIMEOUT;
   logic        DISABLE_VETO;
   logic        FIFO_NEAR_FULL;
   logic        CLR;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_DATA;
   logic        TLU_BUSY;
   logic        TLU_CLOCK;
   logic [31:0] TRIG_CNT;
   logic [15:0] DROP_CNT;
   logic        TIMEOUT_ERR;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  mask;
      logic [3:0]  pins;
      logic        nearFull;
      logic        expValid;
      logic [31:0] expData;
      logic [31:0] expCnt;
      logic [15:0] expDrop;
   } vec_t;

   vec_t vecs[9];

   tlu_handshake_core #(.N_INPUTS(4), .TRIG_WIDTH(15), .DIVISOR(12)) dut (
      .BUS_CLK        (BUS_CLK),
      .BUS_RST_N      (BUS_RST_N),
      .TRIG_IN        (TRIG_IN),
      .CHAN_MASK      (CHAN_MASK),
      .MODE           (MODE),
      .MSB_FIRST      (MSB_FIRST),
      .DATA_DELAY     (DATA_DELAY),
      .LOW_TIMEOUT    (LOW_TIMEOUT),
      .DISABLE_VETO   (DISABLE_VETO),
      .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
      .CLR            (CLR),
      .OUT_VALID      (OUT_VALID),
      .OUT_READY      (OUT_READY),
      .OUT_DATA       (OUT_DATA),
      .TLU_BUSY       (TLU_BUSY),
      .TLU_CLOCK      (TLU_CLOCK),
      .TRIG_CNT       (TRIG_CNT),
      .DROP_CNT       (DROP_CNT),
      .TIMEOUT_ERR    (TIMEOUT_ERR)
   );

   // Free-running bus clock
   always #5 BUS_CLK = ~BUS_CLK;

   task automatic tick();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One trigger pulse of eight cycles, watching up to twenty cycles for a word
   task automatic applyStimulus(input vec_t v, output logic seen, output logic [31:0] data);
      MODE           = v.mode;
      CHAN_MASK      = v.mask;
      FIFO_NEAR_FULL = v.nearFull;
      OUT_READY      = 1'b0;
      TRIG_IN        = v.pins;
      seen           = 1'b0;
      data           = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc == 8) TRIG_IN = 4'b0000;
         tick();
         if (OUT_VALID && !seen) begin
            seen = 1'b1;
            data = OUT_DATA;
         end
      end
      if (seen) begin
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
      end
      repeat (6) tick();
   endtask

   // Mode 11 transfer with the bench acting as TLU, changing data on each TLU_CLOCK rise
   task automatic runShift(input logic [14:0] value, input logic msbFirst,
                           input logic [31:0] expData, input logic [31:0] expCnt);
      int   rises;
      int   falls;
      logic prevClk;
      logic seen;
      MODE        = 2'b11;
      MSB_FIRST   = msbFirst;
      CHAN_MASK   = 4'b0001;
      DATA_DELAY  = 4'd3;
      LOW_TIMEOUT = 8'd0;
      OUT_READY   = 1'b0;
      TRIG_IN     = 4'b0001;
      for (int n = 0; n < 20 && !TLU_BUSY; n++) tick();
      checkOutput("shift_busy_on_accept", {31'd0, TLU_BUSY}, 32'd1);
      TRIG_IN = 4'b0000;
      rises   = 0;
      falls   = 0;
      prevClk = 1'b0;
      seen    = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         tick();
         if (TLU_CLOCK && !prevClk) begin
            if (rises < 15) TRIG_IN[0] = msbFirst ? value[14 - rises] : value[rises];
            rises++;
         end
         if (!TLU_CLOCK && prevClk) falls++;
         prevClk = TLU_CLOCK;
         if (OUT_VALID) seen = 1'b1;
      end
      TRIG_IN = 4'b0000;
      checkOutput("shift_valid", {31'd0, seen}, 32'd1);
      checkOutput("shift_data", OUT_DATA, expData);
      checkOutput("shift_clk_rises", rises, 32'd15);
      checkOutput("shift_clk_falls", falls, 32'd15);
      checkOutput("shift_clk_low", {31'd0, TLU_CLOCK}, 32'd0);
      checkOutput("shift_busy_during_emit", {31'd0, TLU_BUSY}, 32'd1);
      checkOutput("shift_trig_cnt", TRIG_CNT, expCnt);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      checkOutput("shift_valid_drop", {31'd0, OUT_VALID}, 32'd0);
      checkOutput("shift_busy_released", {31'd0, TLU_BUSY}, 32'd0);
      repeat (6) tick();
   endtask

   initial begin
      logic        seen;
      logic [31:0] data;
      logic        stable;
      int          n;

      vecs[0] = '{2'b01, 4'b0010, 4'b0010, 1'b0, 1'b1, 32'h80000001, 32'd1, 16'd0};
      vecs[1] = '{2'b01, 4'b0010, 4'b0001, 1'b0, 1'b0, 32'h00000000, 32'd1, 16'd0};
      vecs[2] = '{2'b01, 4'b1111, 4'b1000, 1'b0, 1'b1, 32'h80000002, 32'd2, 16'd0};
      vecs[3] = '{2'b01, 4'b1111, 4'b1000, 1'b1, 1'b0, 32'h00000000, 32'd2, 16'd1};
      vecs[4] = '{2'b00, 4'b1111, 4'b0100, 1'b0, 1'b0, 32'h00000000, 32'd2, 16'd1};
      vecs[5] = '{2'b01, 4'b0101, 4'b0110, 1'b0, 1'b1, 32'h80000003, 32'd3, 16'd1};
      vecs[6] = '{2'b01, 4'b0000, 4'b1111, 1'b0, 1'b0, 32'h00000000, 32'd3, 16'd1};
      vecs[7] = '{2'b10, 4'b0001, 4'b0001, 1'b0, 1'b1, 32'h80000004, 32'd4, 16'd1};
      vecs[8] = '{2'b01, 4'b1111, 4'b0011, 1'b1, 1'b0, 32'h00000000, 32'd4, 16'd2};

      BUS_RST_N      = 1'b0;
      TRIG_IN        = 4'b0000;
      CHAN_MASK      = 4'b1111;
      MODE           = 2'b00;
      MSB_FIRST      = 1'b0;
      DATA_DELAY     = 4'd3;
      LOW_TIMEOUT    = 8'd0;
      DISABLE_VETO   = 1'b0;
      FIFO_NEAR_FULL = 1'b0;
      CLR            = 1'b0;
      OUT_READY      = 1'b0;
      repeat (3) tick();

      checkOutput("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      checkOutput("rst_out_data", OUT_DATA, 32'd0);
      checkOutput("rst_tlu_busy", {31'd0, TLU_BUSY}, 32'd0);
      checkOutput("rst_tlu_clock", {31'd0, TLU_CLOCK}, 32'd0);
      checkOutput("rst_trig_cnt", TRIG_CNT, 32'd0);
      checkOutput("rst_drop_cnt", {16'd0, DROP_CNT}, 32'd0);
      checkOutput("rst_timeout_err", {31'd0, TIMEOUT_ERR}, 32'd0);
      BUS_RST_N = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], seen, data);
         checkOutput($sformatf("vec%0d_valid", i), {31'd0, seen}, {31'd0, vecs[i].expValid});
         if (vecs[i].expValid) checkOutput($sformatf("vec%0d_data", i), data, vecs[i].expData);
         checkOutput($sformatf("vec%0d_trig_cnt", i), TRIG_CNT, vecs[i].expCnt);
         checkOutput($sformatf("vec%0d_drop_cnt", i), {16'd0, DROP_CNT}, {16'd0, vecs[i].expDrop});
         checkOutput($sformatf("vec%0d_idle_valid", i), {31'd0, OUT_VALID}, 32'd0);
      end

      // Veto in IDLE follows near-full unless disabled
      MODE           = 2'b10;
      FIFO_NEAR_FULL = 1'b1;
      DISABLE_VETO   = 1'b0;
      tick();
      checkOutput("veto_on", {31'd0, TLU_BUSY}, 32'd1);
      DISABLE_VETO = 1'b1;
      tick();
      checkOutput("veto_disabled", {31'd0, TLU_BUSY}, 32'd0);
      FIFO_NEAR_FULL = 1'b0;
      DISABLE_VETO   = 1'b0;
      tick();

      // Mode 10 with the stream stalled for 50 cycles
      MODE      = 2'b10;
      CHAN_MASK = 4'b0001;
      OUT_READY = 1'b0;
      TRIG_IN   = 4'b0001;
      seen      = 1'b0;
      for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
         if (cyc == 8) TRIG_IN = 4'b0000;
         tick();
         if (OUT_VALID) seen = 1'b1;
      end
      TRIG_IN = 4'b0000;
      checkOutput("bp_valid", {31'd0, seen}, 32'd1);
      checkOutput("bp_data", OUT_DATA, 32'h80000005);
      data   = OUT_DATA;
      stable = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
         tick();
         if (!OUT_VALID || OUT_DATA !== data || !TLU_BUSY) stable = 1'b0;
      end
      checkOutput("bp_stable_50", {31'd0, stable}, 32'd1);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      checkOutput("bp_taken_first_ready", {31'd0, OUT_VALID}, 32'd0);
      checkOutput("bp_busy_released", {31'd0, TLU_BUSY}, 32'd0);
      repeat (4) tick();

      // Mode 11 data handshake, both bit orders
      runShift(15'h1234, 1'b0, 32'h80001234, 32'd6);
      runShift(15'h5A3C, 1'b1, 32'h80005A3C, 32'd7);

      // Low timeout with the trigger line stuck high
      MODE        = 2'b10;
      CHAN_MASK   = 4'b0001;
      LOW_TIMEOUT = 8'd20;
      OUT_READY   = 1'b1;
      TRIG_IN     = 4'b0001;
      for (int cyc = 0; cyc < 20 && !TLU_BUSY; cyc++) tick();
      checkOutput("to_busy", {31'd0, TLU_BUSY}, 32'd1);
      n    = 0;
      seen = 1'b0;
      while (!TIMEOUT_ERR && n < 100) begin
         tick();
         n++;
         if (OUT_VALID) seen = 1'b1;
      end
      checkOutput("to_cycles", n, 32'd20);
      checkOutput("to_err", {31'd0, TIMEOUT_ERR}, 32'd1);
      checkOutput("to_busy_released", {31'd0, TLU_BUSY}, 32'd0);
      repeat (5) begin
         tick();
         if (OUT_VALID) seen = 1'b1;
      end
      checkOutput("to_no_word", {31'd0, seen}, 32'd0);
      checkOutput("to_trig_cnt", TRIG_CNT, 32'd8);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      checkOutput("clr_timeout_err", {31'd0, TIMEOUT_ERR}, 32'd0);
      checkOutput("clr_trig_cnt", TRIG_CNT, 32'd0);
      checkOutput("clr_drop_cnt", {16'd0, DROP_CNT}, 32'd0);
      TRIG_IN     = 4'b0000;
      LOW_TIMEOUT = 8'd0;
      OUT_READY   = 1'b0;
      repeat (6) tick();

      // Three triggers dropped while near full in mode 01
      MODE           = 2'b01;
      CHAN_MASK      = 4'b1111;
      FIFO_NEAR_FULL = 1'b1;
      seen           = 1'b0;
      repeat (3) begin
         TRIG_IN = 4'b0100;
         repeat (6) begin tick(); if (OUT_VALID) seen = 1'b1; end
         TRIG_IN = 4'b0000;
         repeat (6) begin tick(); if (OUT_VALID) seen = 1'b1; end
      end
      checkOutput("drop_cnt_3", {16'd0, DROP_CNT}, 32'd3);
      checkOutput("drop_trig_cnt", TRIG_CNT, 32'd0);
      checkOutput("drop_no_word", {31'd0, seen}, 32'd0);
      FIFO_NEAR_FULL = 1'b0;

      // Clear in the same cycle as an accept: counter ends at zero, word still emitted
      CLR = 1'b1;
      tick();
      CLR     = 1'b0;
      TRIG_IN = 4'b0001;
      repeat (3) tick();
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      checkOutput("clr_inc_trig_cnt", TRIG_CNT, 32'd0);
      checkOutput("clr_inc_valid", {31'd0, OUT_VALID}, 32'd1);
      checkOutput("clr_inc_data", OUT_DATA, 32'h80000001);
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      TRIG_IN   = 4'b0000;
      repeat (6) tick();

      // Reset in the middle of a mode 11 transfer
      MODE      = 2'b11;
      CHAN_MASK = 4'b0001;
      TRIG_IN   = 4'b0001;
      for (int cyc = 0; cyc < 20 && !TLU_BUSY; cyc++) tick();
      TRIG_IN = 4'b0000;
      n = 0;
      begin
         logic prevClk;
         prevClk = 1'b0;
         for (int cyc = 0; cyc < 200 && n < 3; cyc++) begin
            tick();
            if (TLU_CLOCK && !prevClk) n++;
            prevClk = TLU_CLOCK;
         end
      end
      checkOutput("rstmid_in_shift", n, 32'd3);
      checkOutput("rstmid_cnt_before", TRIG_CNT, 32'd1);
      BUS_RST_N = 1'b0;
      tick();
      checkOutput("rstmid_tlu_clock", {31'd0, TLU_CLOCK}, 32'd0);
      checkOutput("rstmid_tlu_busy", {31'd0, TLU_BUSY}, 32'd0);
      checkOutput("rstmid_trig_cnt", TRIG_CNT, 32'd0);
      checkOutput("rstmid_out_data", OUT_DATA, 32'd0);
      BUS_RST_N = 1'b1;
      OUT_READY = 1'b1;
      seen      = 1'b0;
      repeat (200) begin
         tick();
         if (OUT_VALID) seen = 1'b1;
      end
      checkOutput("rstmid_no_word", {31'd0, seen}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
